rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
Oldest-first issue scheduler for the reservation station. Each cycle it selects at most one ready, not-yet-issued RS entry per functional-unit port and presents it to that FU with a valid/ready handshake. It tracks allocation age with an age matrix so older instructions win. It sits between the RS entry array (alloc/free/ready status) and the FU input muxes, and replaces the per-entry issue-valid fan-out.

Parameters:
NUM_RS, 6, number of RS entries; entries are numbered 1..NUM_RS, bit i-1 of every vector is entry i
RS_TAG_W, 3, width of an entry number; value 0 means "no entry"
NUM_PORTS, 3, number of FU issue ports (0=ALU, 1=MEM, 2=MULT)
PORT_W, 2, width of a port id

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
squash  in  1  synchronous flush, same effect as reset
alloc_valid  in  1  an entry is allocated this cycle
alloc_idx  in  RS_TAG_W  entry being allocated (1..NUM_RS; other values ignored)
free_vec  in  NUM_RS  entries freed this cycle (CDB completion)
ready_vec  in  NUM_RS  entry operands both valid
entry_port  in  NUM_RS*PORT_W  static port id per entry; slice i-1 is entry i
fu_ready  in  NUM_PORTS  FU on port p accepts this cycle
issue_valid  out  NUM_PORTS  port p presents an entry
issue_idx  out  NUM_PORTS*RS_TAG_W  entry number on port p; 0 when not valid
issued_vec  out  NUM_RS  entry has been granted and is awaiting free

Behaviour:
- State: tracked[NUM_RS]; issued[NUM_RS]; older[NUM_RS][NUM_RS], where older[i][j]=1 means j was allocated before i; and per-port output registers (valid, idx).
- Reset or squash at the edge: clear all state. issue_valid=0, issue_idx=0, issued_vec=0. Squash dominates alloc, free and handshake in the same cycle.
- Alloc, when alloc_valid and 1<=alloc_idx<=NUM_RS:
  - Next cycle: tracked[i]=1, issued[i]=0.
  - Row older[i][*] is set to the current tracked vector, excluding entries freed this cycle and excluding i itself.
  - Column older[*][i] is cleared.
- Free, for bit i of free_vec: next cycle tracked[i]=0 and issued[i]=0, and column older[*][i] is cleared.
  - If alloc and free name the same entry in the same cycle, alloc wins.
  - Frees of untracked entries have no effect.
- candidate[i] = tracked[i] & ready_vec[i] & ~issued[i] & ~free_vec[i].
- Oldest selection: winner on port p is the candidate i with entry_port[i]==p and no candidate j on port p with older[i][j]=1. Ties cannot occur. If they do through an illegal input, the lowest entry number wins.
- Port register update, per port, every cycle:
  - Load condition: issue_valid[p]==0, or (issue_valid[p] & fu_ready[p]). Handshake = issue_valid & fu_ready.
  - If the load condition holds and a winner exists: next issue_valid=1, issue_idx=winner, and issued[winner] is set.
  - If the load condition holds and no winner exists: next issue_valid=0, issue_idx=0.
  - Otherwise (stalled): hold valid and idx stable.
- Cancel: if the held entry is in free_vec while not handshaking this cycle, the next cycle drops issue_valid and idx goes to 0. A new winner may load in that same update.
  - Free and handshake in the same cycle: the handshake counts. The entry is not re-granted.
- Latency:
  - ready_vec high in cycle N on an idle port gives issue_valid in N+1.
  - Alloc in N, ready in N+1, gives issue in N+2.
  - Back-to-back issue on a port is 1 per cycle while fu_ready=1.
- An issued entry stays issued (not re-offered) until freed, even if ready_vec drops.
- issued_vec is issued[] directly. Outputs are registered only; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset: hold reset 2 cycles with ready_vec=all-ones -> issue_valid=0, issue_idx all 0, issued_vec=0. Deassert with nothing tracked -> outputs stay 0.
2. Age order: alloc entry 2 at cycle 0, entry 1 at cycle 1, both port 0; ready_vec=6'b000011 from cycle 2, fu_ready[0]=1.
   - cycle 3: issue_idx[0]=2.
   - cycle 4: issue_idx[0]=1.
   - cycle 5: issue_valid[0]=0.
3. Backpressure: entry 5 (port 2) issued with fu_ready[2]=0 for 3 cycles -> issue_valid[2]=1 and issue_idx[2]=5 stable for all 3. fu_ready=1 -> valid drops next cycle. issued_vec[4]=1 until free_vec[4] pulses.
4. Parallel ports: entries 1(p0), 3(p1), 5(p2) allocated and ready together -> next cycle issue_idx = {5,3,1} (p2,p1,p0), all three valid.
5. Cancel: entry 4 held on port 1, fu_ready=0, free_vec[3]=1 -> next cycle issue_valid[1]=0, issued_vec[3]=0. Realloc entry 4 ready -> re-offered 2 cycles later.
6. Squash mid-operation: 3 entries tracked, 2 held -> squash pulse -> next cycle all outputs 0. Alloc entry 6 ready at cycle +1 -> issue_idx=6 at cycle +3, with no stale older bits blocking it.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Oldest-first issue scheduler for the reservation station.
// An age matrix orders tracked entries by allocation time. Each FU port has a
// registered valid/idx pair that is loaded with the oldest ready, not-yet-issued
// entry on that port. A granted entry stays issued until its entry is freed.

// Per-port picker: returns the oldest candidate, with the lowest entry number
// breaking any tie.
module rs_port_pick #(
    parameter int NUM_RS   = 6,
    parameter int RS_TAG_W = 3
) (
    input  logic [NUM_RS-1:0]             cand_i,
    input  logic [NUM_RS-1:0][NUM_RS-1:0] older_i,
    output logic                          found_o,
    output logic [RS_TAG_W-1:0]           idx_o,
    output logic [NUM_RS-1:0]             oh_o
);
    // An entry wins when no other candidate on this port is older than it.
    always_comb begin
        logic found;
        found   = 1'b0;
        idx_o   = '0;
        oh_o    = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (!found && cand_i[i] && ((older_i[i] & cand_i) == '0)) begin
                found   = 1'b1;
                idx_o   = RS_TAG_W'(i + 1);
                oh_o[i] = 1'b1;
            end
        end
        found_o = found;
    end
endmodule

module rs_issue_scheduler #(
    parameter int NUM_RS    = 6,
    parameter int RS_TAG_W  = 3,
    parameter int NUM_PORTS = 3,
    parameter int PORT_W    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          squash,
    input  logic                          alloc_valid,
    input  logic [RS_TAG_W-1:0]           alloc_idx,
    input  logic [NUM_RS-1:0]             free_vec,
    input  logic [NUM_RS-1:0]             ready_vec,
    input  logic [NUM_RS*PORT_W-1:0]      entry_port,
    input  logic [NUM_PORTS-1:0]          fu_ready,
    output logic [NUM_PORTS-1:0]          issue_valid,
    output logic [NUM_PORTS*RS_TAG_W-1:0] issue_idx,
    output logic [NUM_RS-1:0]             issued_vec
);
    logic [NUM_RS-1:0]                    tracked_q, tracked_d;
    logic [NUM_RS-1:0]                    issued_q, issued_d;
    logic [NUM_RS-1:0][NUM_RS-1:0]        older_q, older_d;
    logic [NUM_PORTS-1:0]                 vld_q, vld_d;
    logic [NUM_PORTS-1:0][RS_TAG_W-1:0]   idx_q, idx_d;

    logic [NUM_RS-1:0]                    alloc_oh;
    logic [NUM_RS-1:0]                    cand;
    logic [NUM_PORTS-1:0][NUM_RS-1:0]     on_port;
    logic [NUM_PORTS-1:0]                 win_found;
    logic [NUM_PORTS-1:0][RS_TAG_W-1:0]   win_idx;
    logic [NUM_PORTS-1:0][NUM_RS-1:0]     win_oh;
    logic [NUM_PORTS-1:0]                 held_free;

    // Decode the allocation (out-of-range numbers are dropped) and split the
    // candidates by their static port; a held entry being freed is flagged.
    always_comb begin
        alloc_oh  = '0;
        on_port   = '0;
        held_free = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (alloc_valid && alloc_idx == RS_TAG_W'(i + 1))
                alloc_oh[i] = 1'b1;
        end
        cand = tracked_q & ready_vec & ~issued_q & ~free_vec;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int i = 0; i < NUM_RS; i++) begin
                on_port[p][i] = cand[i] && (entry_port[i*PORT_W +: PORT_W] == PORT_W'(p));
                if (vld_q[p] && idx_q[p] == RS_TAG_W'(i + 1) && free_vec[i])
                    held_free[p] = 1'b1;
            end
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PORTS; gp++) begin : g_pick
            rs_port_pick #(.NUM_RS(NUM_RS), .RS_TAG_W(RS_TAG_W)) u_pick (
                .cand_i  (on_port[gp]),
                .older_i (older_q),
                .found_o (win_found[gp]),
                .idx_o   (win_idx[gp]),
                .oh_o    (win_oh[gp])
            );
        end
    endgenerate

    // Next state: frees, then grants, then allocation (alloc beats a free of
    // the same entry). A stalled port reloads early when its entry is cancelled.
    always_comb begin
        tracked_d = (tracked_q & ~free_vec) | alloc_oh;
        issued_d  = issued_q & ~free_vec;
        vld_d     = vld_q;
        idx_d     = idx_q;
        for (int i = 0; i < NUM_RS; i++) begin
            for (int j = 0; j < NUM_RS; j++) begin
                older_d[i][j] = older_q[i][j] & ~free_vec[j] & ~alloc_oh[j];
            end
            if (alloc_oh[i])
                older_d[i] = tracked_q & ~free_vec & ~alloc_oh;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!vld_q[p] || fu_ready[p] || held_free[p]) begin
                vld_d[p] = win_found[p];
                idx_d[p] = win_found[p] ? win_idx[p] : '0;
                if (win_found[p])
                    issued_d = issued_d | win_oh[p];
            end
        end
        issued_d = issued_d & ~alloc_oh;
    end

    // State registers; reset and squash both wipe everything.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            tracked_q <= '0;
            issued_q  <= '0;
            older_q   <= '0;
            vld_q     <= '0;
            idx_q     <= '0;
        end else begin
            tracked_q <= tracked_d;
            issued_q  <= issued_d;
            older_q   <= older_d;
            vld_q     <= vld_d;
            idx_q     <= idx_d;
        end
    end

    assign issue_valid = vld_q;
    assign issue_idx   = idx_q;
    assign issued_vec  = issued_q;
endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Table-driven bench for rs_issue_scheduler. Each row is one clock cycle of
// inputs plus the outputs expected right after that edge. Expected values are
// pushed to a scoreboard queue when a row is driven and popped after the edge.
module tb_rs_issue_scheduler;
    logic       clock = 1'b0;
    logic       reset, squash, alloc_valid;
    logic [2:0] alloc_idx;
    logic [5:0] free_vec, ready_vec;
    logic [11:0] entry_port;
    logic [2:0] fu_ready;
    logic [2:0] issue_valid;
    logic [8:0] issue_idx;
    logic [5:0] issued_vec;

    rs_issue_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .alloc_valid (alloc_valid),
        .alloc_idx   (alloc_idx),
        .free_vec    (free_vec),
        .ready_vec   (ready_vec),
        .entry_port  (entry_port),
        .fu_ready    (fu_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .issued_vec  (issued_vec)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst, sq, av;
        logic [2:0] aidx;
        logic [5:0] fr, rdy;
        logic [2:0] fur;
        logic [2:0] ev;
        logic [8:0] ei;
        logic [5:0] eiss;
    } vec_t;

    typedef struct {
        logic [2:0] ev;
        logic [8:0] ei;
        logic [5:0] eiss;
        int         row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic row(input logic rst, input logic sq, input logic av, input logic [2:0] aidx,
                       input logic [5:0] fr, input logic [5:0] rdy, input logic [2:0] fur,
                       input logic [2:0] ev, input logic [8:0] ei, input logic [5:0] eiss);
        vec_t v;
        v.rst = rst; v.sq = sq; v.av = av; v.aidx = aidx; v.fr = fr; v.rdy = rdy;
        v.fur = fur; v.ev = ev; v.ei = ei; v.eiss = eiss;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int r, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s row %0d: got %0h want %0h", name, r, act, exp);
        end
    endtask

    // Idx packing helper: {p2,p1,p0}, 3 bits each.
    function automatic logic [8:0] pk(input int p2, input int p1, input int p0);
        return {3'(p2), 3'(p1), 3'(p0)};
    endfunction

    initial begin
        exp_t e;
        // Entry ports: e1=ALU, e2=ALU, e3=MEM, e4=MEM, e5=MULT, e6=ALU
        entry_port = {2'd0, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

        // Reset held with everything ready, then deassert with nothing tracked
        row(1,0,0,0, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(1,0,0,0, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);
        // Out-of-range alloc numbers are ignored
        row(0,0,1,0, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,7, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h3F,3'b111, 3'b000,pk(0,0,0),6'h00);

        // Age order: entry 2 then entry 1 on ALU; older one goes first
        row(0,0,1,2, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,1, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h03,3'b111, 3'b001,pk(0,0,2),6'h02);
        row(0,0,0,0, 6'h00,6'h03,3'b111, 3'b001,pk(0,0,1),6'h03);
        row(0,0,0,0, 6'h00,6'h03,3'b111, 3'b000,pk(0,0,0),6'h03);
        row(0,0,0,0, 6'h03,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);

        // Backpressure on MULT: entry 5 held 3 cycles, ready drop does not matter
        row(0,0,1,5, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h10,3'b011, 3'b100,pk(5,0,0),6'h10);
        row(0,0,0,0, 6'h00,6'h10,3'b011, 3'b100,pk(5,0,0),6'h10);
        row(0,0,0,0, 6'h00,6'h10,3'b011, 3'b100,pk(5,0,0),6'h10);
        row(0,0,0,0, 6'h00,6'h00,3'b011, 3'b100,pk(5,0,0),6'h10);
        row(0,0,0,0, 6'h00,6'h10,3'b111, 3'b000,pk(0,0,0),6'h10);
        row(0,0,0,0, 6'h00,6'h10,3'b111, 3'b000,pk(0,0,0),6'h10);
        row(0,0,0,0, 6'h10,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);

        // Parallel ports: 1/3/5 ready together issue on all three
        row(0,0,1,1, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,3, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,5, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h15,3'b111, 3'b111,pk(5,3,1),6'h15);
        row(0,0,0,0, 6'h00,6'h15,3'b111, 3'b000,pk(0,0,0),6'h15);
        row(0,0,0,0, 6'h15,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);

        // Cancel: entry 4 stalled on MEM is freed, then reallocated and re-offered
        row(0,0,1,4, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h08,3'b101, 3'b010,pk(0,4,0),6'h08);
        row(0,0,0,0, 6'h00,6'h08,3'b101, 3'b010,pk(0,4,0),6'h08);
        row(0,0,0,0, 6'h08,6'h08,3'b101, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,4, 6'h00,6'h08,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h08,3'b111, 3'b010,pk(0,4,0),6'h08);
        row(0,0,0,0, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h08);

        // Squash mid-operation (with a competing alloc of 2), then entry 6
        row(0,0,1,1, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h08);
        row(0,0,1,5, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h08);
        row(0,0,0,0, 6'h00,6'h11,3'b000, 3'b101,pk(5,0,1),6'h19);
        row(0,0,0,0, 6'h00,6'h11,3'b000, 3'b101,pk(5,0,1),6'h19);
        row(0,1,1,2, 6'h00,6'h11,3'b000, 3'b000,pk(0,0,0),6'h00);
        row(0,0,1,6, 6'h00,6'h22,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h22,3'b111, 3'b001,pk(0,0,6),6'h20);
        row(0,0,0,0, 6'h00,6'h00,3'b111, 3'b000,pk(0,0,0),6'h20);
        // Alloc and free of the same entry: alloc wins, entry stays tracked
        row(0,0,1,6, 6'h20,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);
        row(0,0,0,0, 6'h00,6'h20,3'b111, 3'b001,pk(0,0,6),6'h20);
        row(0,0,0,0, 6'h20,6'h00,3'b111, 3'b000,pk(0,0,0),6'h00);

        foreach (tbl[k]) begin
            @(negedge clock);
            reset       = tbl[k].rst;
            squash      = tbl[k].sq;
            alloc_valid = tbl[k].av;
            alloc_idx   = tbl[k].aidx;
            free_vec    = tbl[k].fr;
            ready_vec   = tbl[k].rdy;
            fu_ready    = tbl[k].fur;
            e.ev = tbl[k].ev; e.ei = tbl[k].ei; e.eiss = tbl[k].eiss; e.row = k;
            sb.push_back(e);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            chk("issue_valid", e.row, 9'(issue_valid), 9'(e.ev));
            chk("issue_idx",   e.row, issue_idx,       e.ei);
            chk("issued_vec",  e.row, 9'(issued_vec),  9'(e.eiss));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
